// File: rtl/port_sample_seq.sv
// Machine-cycle-aware input port sampler: channel select, optional input synchroniser,
// and transparent / cycle-capture / edge-accumulate / hold result modes.
// Optional feature: define PORT_SAMPLE_SYNC_EN to add a 2-flop synchroniser on every ch_in bit.
module port_sample_seq #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int CYCLE_LEN = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [CHANNELS*WIDTH-1:0]     ch_in,
  input  logic [$clog2(CHANNELS)-1:0]   sel,
  input  logic [1:0]                    mode,
  input  logic                          rd_ack,
  output logic [WIDTH-1:0]              data_out,
  output logic                          valid,
  output logic                          overrun,
  output logic [$clog2(CYCLE_LEN)-1:0]  phase,
  output logic                          cycle_strobe
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int PH_W  = $clog2(CYCLE_LEN);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYCLE_LEN - 1);

  localparam logic [1:0] MODE_TRANSP = 2'b00;
  localparam logic [1:0] MODE_CAPT   = 2'b01;
  localparam logic [1:0] MODE_ACC    = 2'b10;

  logic [CHANNELS*WIDTH-1:0] w_bus;
  logic [WIDTH-1:0]          w_s;
  logic [WIDTH-1:0]          w_edge;
  logic                      w_last;
  logic                      w_mode_chg;
  logic                      w_upd;

  logic [WIDTH-1:0]          r_data;
  logic                      r_valid;
  logic                      r_overrun;
  logic [PH_W-1:0]           r_phase;
  logic [WIDTH-1:0]          r_acc;
  logic [WIDTH-1:0]          r_prev;
  logic [SEL_W-1:0]          r_sel_q;
  logic [1:0]                r_mode_q;

`ifdef PORT_SAMPLE_SYNC_EN
  logic [CHANNELS*WIDTH-1:0] r_sync1;
  logic [CHANNELS*WIDTH-1:0] r_sync2;

  // Synchroniser ignores ena so the pad path keeps settling while the core is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ch_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_bus = r_sync2;
`else
  assign w_bus = ch_in;
`endif

  // Out-of-range selects fall through to channel 0.
  always_comb begin
    w_s = w_bus[0 +: WIDTH];
    for (int k = 1; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        w_s = w_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_last       = (r_phase == PH_LAST);
  assign cycle_strobe = ena & w_last;
  assign w_mode_chg   = (mode != r_mode_q);
  assign w_edge       = (sel != r_sel_q) ? '0 : (w_s & ~r_prev);
  assign w_upd        = w_last & ((mode == MODE_CAPT) | (mode == MODE_ACC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_phase   <= '0;
      r_acc     <= '0;
      r_prev    <= '0;
      r_sel_q   <= '0;
      r_mode_q  <= '0;
    end else if (ena) begin
      r_phase  <= w_last ? '0 : r_phase + 1'b1;
      r_prev   <= w_s;
      r_sel_q  <= sel;
      r_mode_q <= mode;

      if (w_mode_chg) begin
        r_acc <= '0;
      end else if (mode == MODE_ACC) begin
        r_acc <= w_last ? '0 : (r_acc | w_edge);
      end

      if (mode == MODE_TRANSP) begin
        r_data  <= w_s;
        r_valid <= 1'b1;
      end else if (w_upd) begin
        r_data  <= (mode == MODE_CAPT) ? w_s : (r_acc | w_edge);
        r_valid <= 1'b1;
        if (r_valid && !rd_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (rd_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;
  assign overrun  = r_overrun;
  assign phase    = r_phase;

endmodule
